// File: rtl/axi_mon_pkg.sv
// Shared constants and types for the AXI transaction monitor.
// Status byte codes, error bit positions and the status vector layout.
package axi_mon_pkg;

    localparam logic [7:0] ST_AW = 8'hFF;
    localparam logic [7:0] ST_W  = 8'hFE;
    localparam logic [7:0] ST_B  = 8'hFD;
    localparam logic [7:0] ST_AR = 8'hFC;
    localparam logic [7:0] ST_R  = 8'hFB;

    localparam int ERR_ORPHAN_B   = 0;
    localparam int ERR_ORPHAN_R   = 1;
    localparam int ERR_VALID_DROP = 2;
    localparam int ERR_OVERFLOW   = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] ar;
        logic [7:0] b;
        logic [7:0] w;
        logic [7:0] aw;
    } axi_mon_status_t;

    function automatic logic [7:0] st_code(input logic hs, input logic [7:0] code);
        return hs ? code : 8'h00;
    endfunction

endpackage

// File: rtl/axi_txn_monitor_if.sv
// AXI3/AXI4 five-channel bundle for one slave port.
// The monitor only ever uses the all-input view.
interface axi_txn_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6
);
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awid, awvalid, wdata, wlast, wvalid, bready,
        output araddr, arid, arvalid, rready,
        input  awready, wready, bresp, bid, bvalid,
        input  arready, rdata, rresp, rid, rlast, rvalid
    );

    modport slave (
        input  awaddr, awid, awvalid, wdata, wlast, wvalid, bready,
        input  araddr, arid, arvalid, rready,
        output awready, wready, bresp, bid, bvalid,
        output arready, rdata, rresp, rid, rlast, rvalid
    );

    modport mon (
        input awaddr, awid, awvalid, awready, wdata, wlast, wvalid, wready,
        input bresp, bid, bvalid, bready, araddr, arid, arvalid, arready,
        input rdata, rresp, rid, rlast, rvalid, rready
    );

endinterface

// File: rtl/axi_mon_ts_fifo.sv
// Timestamp FIFO holding issue times of outstanding transactions.
// Caller only pops when non-empty and only pushes when not full or popping.
module axi_mon_ts_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;

    // advance pointers and occupancy; push+pop leaves occupancy unchanged
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = wp_q + 1'b1;
        if (pop)  rp_d = rp_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // pointer/occupancy state, emptied by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end

    assign dout  = mem_q[rp_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/axi_txn_monitor.sv
// Passive AXI slave-port monitor: handshake status, in-order latency,
// completion counts and sticky protocol errors. Never drives the bus.
module axi_txn_monitor
    import axi_mon_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 6,
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = 32,
    parameter int LAT_W     = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         clr_stats,
    axi_txn_monitor_if.mon               bus,
    output logic [39:0]                  status_vec,
    output logic [CNT_W-1:0]             wr_cnt,
    output logic [CNT_W-1:0]             rd_cnt,
    output logic [$clog2(MAX_OUTST):0]   wr_outst,
    output logic [$clog2(MAX_OUTST):0]   rd_outst,
    output logic [LAT_W-1:0]             wr_lat_max,
    output logic [LAT_W-1:0]             rd_lat_max,
    output logic [3:0]                   err
);
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int PAYLOAD_W = 2*ADDR_W + 2*DATA_W + 4*ID_W + 5;

    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, rd_done;
    logic [4:0] vld, rdy;

    assign hs_aw   = bus.awvalid & bus.awready;
    assign hs_w    = bus.wvalid  & bus.wready;
    assign hs_b    = bus.bvalid  & bus.bready;
    assign hs_ar   = bus.arvalid & bus.arready;
    assign hs_r    = bus.rvalid  & bus.rready;
    assign rd_done = hs_r & bus.rlast;
    assign vld = {bus.rvalid, bus.arvalid, bus.bvalid, bus.wvalid, bus.awvalid};
    assign rdy = {bus.rready, bus.arready, bus.bready, bus.wready, bus.awready};

    logic [PAYLOAD_W-1:0] unused_payload;
    assign unused_payload = {bus.awaddr, bus.awid, bus.wdata, bus.wlast,
                             bus.bresp, bus.bid, bus.araddr, bus.arid,
                             bus.rdata, bus.rresp, bus.rid};

    logic [LAT_W-1:0] ts_q, ts_d;
    logic [LAT_W-1:0] wr_ts, rd_ts, wr_lat, rd_lat;
    logic [OW-1:0]    wr_count, rd_count;
    logic wr_full, wr_empty, wr_push, wr_pop;
    logic rd_full, rd_empty, rd_push, rd_pop;

    // a pop on an empty tracker is an orphan; a push on a full one is dropped
    assign wr_pop  = hs_b & ~wr_empty;
    assign wr_push = hs_aw & (~wr_full | wr_pop);
    assign rd_pop  = rd_done & ~rd_empty;
    assign rd_push = hs_ar & (~rd_full | rd_pop);
    assign wr_lat  = ts_q - wr_ts;
    assign rd_lat  = ts_q - rd_ts;

    axi_mon_ts_fifo #(.DEPTH(MAX_OUTST), .W(LAT_W)) u_wr_trk (
        .clk(ACLK), .rst(ARESET), .push(wr_push), .pop(wr_pop),
        .din(ts_q), .dout(wr_ts), .count(wr_count),
        .full(wr_full), .empty(wr_empty)
    );

    axi_mon_ts_fifo #(.DEPTH(MAX_OUTST), .W(LAT_W)) u_rd_trk (
        .clk(ACLK), .rst(ARESET), .push(rd_push), .pop(rd_pop),
        .din(ts_q), .dout(rd_ts), .count(rd_count),
        .full(rd_full), .empty(rd_empty)
    );

    axi_mon_status_t  status_q, status_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0] wr_lat_max_q, wr_lat_max_d, rd_lat_max_q, rd_lat_max_d;
    logic [3:0]       err_q, err_d;
    logic [4:0]       pend_q, pend_d;

    // next-state: clear first, then this cycle's events on top of it
    always_comb begin
        ts_d        = ts_q + 1'b1;
        status_d.aw = st_code(hs_aw, ST_AW);
        status_d.w  = st_code(hs_w,  ST_W);
        status_d.b  = st_code(hs_b,  ST_B);
        status_d.ar = st_code(hs_ar, ST_AR);
        status_d.r  = st_code(hs_r,  ST_R);
        pend_d      = vld & ~rdy;

        wr_cnt_d     = clr_stats ? '0 : wr_cnt_q;
        rd_cnt_d     = clr_stats ? '0 : rd_cnt_q;
        wr_lat_max_d = clr_stats ? '0 : wr_lat_max_q;
        rd_lat_max_d = clr_stats ? '0 : rd_lat_max_q;
        err_d        = clr_stats ? '0 : err_q;

        if (hs_b && wr_cnt_d != '1)    wr_cnt_d = wr_cnt_d + 1'b1;
        if (rd_done && rd_cnt_d != '1) rd_cnt_d = rd_cnt_d + 1'b1;
        if (wr_pop && wr_lat > wr_lat_max_d) wr_lat_max_d = wr_lat;
        if (rd_pop && rd_lat > rd_lat_max_d) rd_lat_max_d = rd_lat;

        if (hs_b && wr_empty)      err_d[ERR_ORPHAN_B]   = 1'b1;
        if (rd_done && rd_empty)   err_d[ERR_ORPHAN_R]   = 1'b1;
        if (|(pend_q & ~vld))      err_d[ERR_VALID_DROP] = 1'b1;
        if ((hs_aw && wr_full && !wr_pop) || (hs_ar && rd_full && !rd_pop))
            err_d[ERR_OVERFLOW] = 1'b1;
    end

    // registered outputs and bookkeeping state
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ts_q         <= '0;
            status_q     <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_lat_max_q <= '0;
            rd_lat_max_q <= '0;
            err_q        <= '0;
            pend_q       <= '0;
        end else begin
            ts_q         <= ts_d;
            status_q     <= status_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_lat_max_q <= wr_lat_max_d;
            rd_lat_max_q <= rd_lat_max_d;
            err_q        <= err_d;
            pend_q       <= pend_d;
        end
    end

    assign status_vec = status_q;
    assign wr_cnt     = wr_cnt_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_outst   = wr_count;
    assign rd_outst   = rd_count;
    assign wr_lat_max = wr_lat_max_q;
    assign rd_lat_max = rd_lat_max_q;
    assign err        = err_q;

endmodule
